// File: rtl/sccb_pkg.sv
// Shared definitions for the dual-camera SCCB register-config path.
package sccb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  // Layout of one 32-bit SCCB write word: {dev_addr, reg_addr, data}
  localparam int DEV_MSB = 31;
  localparam int DEV_LSB = 24;
  localparam int REG_MSB = 23;
  localparam int REG_LSB = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;

  localparam logic [7:0] OV5640_DEV_ADDR = 8'h78;

  function automatic logic [31:0] pack_word(input logic [7:0]  dev_addr,
                                            input logic [15:0] reg_addr,
                                            input logic [7:0]  dat);
    logic [31:0] w;
    w = '0;
    w[DEV_MSB:DEV_LSB] = dev_addr;
    w[REG_MSB:REG_LSB] = reg_addr;
    w[DAT_MSB:DAT_LSB] = dat;
    return w;
  endfunction

endpackage

// File: rtl/sccb_dual_arbiter.sv
// Round-robin arbiter sharing one SCCB byte-write engine between cam0 and cam1,
// with an enforced idle gap between transactions and a per-transaction timeout.
module sccb_dual_arbiter
  import sccb_pkg::*;
#(
  parameter int GAP_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TO_W           = 22
) (
  input  logic        clk_25M,
  input  logic        camera_rstn,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        eng_start,
  output logic [31:0] eng_data,
  output logic        eng_abort,
  input  logic        eng_done,
  input  logic        eng_nack,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic            last;
  logic [TO_W-1:0] cnt;
  logic            any_req;
  logic            sel;
  logic            timeout_hit;
  logic            gap_end;
  logic            wait_end;

  always_comb begin
    any_req     = req0 | req1;
    // A tie goes to whoever was not served last
    sel         = (req0 & req1) ? ~last : req1;
    timeout_hit = (cnt == TO_W'(TIMEOUT_CYCLES - 1));
    gap_end     = (cnt == TO_W'(GAP_CYCLES - 1));
    wait_end    = eng_done | timeout_hit;
  end

  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)  state_nxt = LAUNCH;
      LAUNCH:                state_nxt = WAIT;
      WAIT:    if (wait_end) state_nxt = GAP;
      GAP:     if (gap_end)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LAUNCH: begin
        eng_start = 1'b1;
        gnt0      = ~last;
        gnt1      = last;
      end
      WAIT: begin
        gnt0      = ~last;
        gnt1      = last;
        done0     = wait_end & ~last;
        done1     = wait_end & last;
        // A completion on the timeout cycle takes precedence over the timeout
        err0      = done0 & (eng_done ? eng_nack : 1'b1);
        err1      = done1 & (eng_done ? eng_nack : 1'b1);
        eng_abort = timeout_hit & ~eng_done;
      end
      default: ;
    endcase
  end

  // last doubles as the owner of the current transaction
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      eng_data <= '0;
      last     <= 1'b1;
    end else if (state == IDLE && any_req) begin
      eng_data <= sel ? data1 : data0;
      last     <= sel;
    end
  end

  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      cnt <= '0;
    end else begin
      case (state)
        WAIT:    cnt <= wait_end ? '0 : cnt + TO_W'(1);
        GAP:     cnt <= gap_end  ? '0 : cnt + TO_W'(1);
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      err_cnt <= '0;
    end else if ((err0 | err1) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sccb_dual_arbiter.sv
// Bench for sccb_dual_arbiter: directed vector table, corner sequences and a
// randomized run against a timestamp-based transaction model.
module tb_sccb_dual_arbiter;
  import sccb_pkg::*;

  localparam int GAP  = 32;
  localparam int TMO  = 100;
  localparam int TO_W = 22;

  logic        clk_25M = 1'b0;
  logic        camera_rstn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        eng_done = 1'b0, eng_nack = 1'b0;
  logic        gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_abort, busy;
  logic [31:0] eng_data;
  logic [7:0]  err_cnt;

  sccb_dual_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .TO_W(TO_W)) dut (
    .clk_25M(clk_25M), .camera_rstn(camera_rstn),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .eng_start(eng_start), .eng_data(eng_data),
    .eng_abort(eng_abort), .eng_done(eng_done), .eng_nack(eng_nack),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #20 clk_25M = ~clk_25M;

  typedef struct packed {
    logic        gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_abort, busy;
    logic [31:0] eng_data;
    logic [7:0]  err_cnt;
  } obs_t;

  typedef struct {
    int          n;
    logic        req0;
    logic [31:0] data0;
    logic        req1;
    logic [31:0] data1;
    logic        done;
    logic        nack;
    obs_t        exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tv [12];

  // flags = {gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_abort, busy}
  function automatic obs_t mk(input logic [8:0] flags, input logic [31:0] d, input logic [7:0] c);
    obs_t o;
    {o.gnt0, o.gnt1, o.done0, o.done1, o.err0, o.err1, o.eng_start, o.eng_abort, o.busy} = flags;
    o.eng_data = d;
    o.err_cnt  = c;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk({gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_abort, busy}, eng_data, err_cnt);
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (flags g0 g1 d0 d1 e0 e1 st ab bz | data | cnt)", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_25M);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [31:0] d0, input logic r1,
                       input logic [31:0] d1, input logic dn, input logic nk);
    req0 = r0; data0 = d0; req1 = r1; data1 = d1; eng_done = dn; eng_nack = nk;
  endtask

  task automatic reset_dut();
    camera_rstn = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    camera_rstn = 1'b1;
  endtask

  // Reference model state: transactions described by their launch/idle timestamps
  bit          m_active;
  int          m_tl, m_tidle;
  bit          m_owner, m_last;
  logic [31:0] m_edata;
  int          m_errcnt;

  logic [31:0] W0, W1, WX;

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    W0 = 32'h78300882;
    W1 = pack_word(OV5640_DEV_ADDR, 16'h4300, 8'h30);
    WX = 32'hDEADBEEF;

    tv[0]  = '{1,       1'b1, W0, 1'b0, '0, 1'b0, 1'b0, mk(9'b000000000, '0, 8'd0)};
    tv[1]  = '{1,       1'b1, W0, 1'b0, '0, 1'b0, 1'b0, mk(9'b100000101, W0, 8'd0)};
    tv[2]  = '{1,       1'b1, W0, 1'b0, '0, 1'b0, 1'b0, mk(9'b100000001, W0, 8'd0)};
    tv[3]  = '{38,      1'b1, W0, 1'b0, '0, 1'b0, 1'b0, mk(9'b100000001, W0, 8'd0)};
    tv[4]  = '{1,       1'b1, W0, 1'b0, '0, 1'b1, 1'b0, mk(9'b101000001, W0, 8'd0)};
    tv[5]  = '{1,       1'b0, W0, 1'b0, '0, 1'b0, 1'b0, mk(9'b000000001, W0, 8'd0)};
    tv[6]  = '{1,       1'b0, W0, 1'b1, W1, 1'b1, 1'b0, mk(9'b000000001, W0, 8'd0)};
    tv[7]  = '{GAP - 2, 1'b0, W0, 1'b1, W1, 1'b0, 1'b0, mk(9'b000000001, W0, 8'd0)};
    tv[8]  = '{1,       1'b0, W0, 1'b1, W1, 1'b0, 1'b0, mk(9'b000000000, W0, 8'd0)};
    tv[9]  = '{1,       1'b0, W0, 1'b1, WX, 1'b0, 1'b0, mk(9'b010000101, W1, 8'd0)};
    tv[10] = '{1,       1'b0, W0, 1'b1, WX, 1'b1, 1'b1, mk(9'b010101001, W1, 8'd0)};
    tv[11] = '{1,       1'b0, W0, 1'b0, WX, 1'b0, 1'b0, mk(9'b000000001, W1, 8'd1)};

    // Reset values while reset is held
    #1;
    check_obs("reset", mk(9'b000000000, '0, 8'd0));
    reset_dut();

    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < tv[i].n; c++) begin
        if (i > 0 || c > 0) step();
        drive(tv[i].req0, tv[i].data0, tv[i].req1, tv[i].data1, tv[i].done, tv[i].nack);
      end
      #1;
      check_obs($sformatf("vec%0d", i), tv[i].exp);
    end

    // Timeout: engine never answers
    reset_dut();
    drive(1'b1, W0, 1'b0, '0, 1'b0, 1'b0);
    step();
    #1;
    check_obs("to_launch", mk(9'b100000101, W0, 8'd0));
    for (int k = 1; k <= TMO; k++) begin
      step();
      #1;
      if (k == TMO - 1) check_val("to_early", {done0, err0, eng_abort}, 3'b000);
      if (k == TMO)     check_obs("to_fire", mk(9'b101010011, W0, 8'd0));
    end
    step();
    drive(1'b0, W0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check_obs("to_gap", mk(9'b000000001, W0, 8'd1));
    repeat (GAP - 1) step();
    step();
    #1;
    check_val("to_idle", busy, 1'b0);

    // Collision: completion lands on the timeout cycle
    reset_dut();
    drive(1'b0, '0, 1'b1, W1, 1'b0, 1'b0);
    step();
    #1;
    check_obs("col_launch", mk(9'b010000101, W1, 8'd0));
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k == TMO) eng_done = 1'b1;
      #1;
      if (k == TMO) check_obs("col_fire", mk(9'b010100001, W1, 8'd0));
    end
    step();
    eng_done = 1'b0;

    // Both requesting continuously, every transaction NACKed: order + saturation
    begin
      int   got;
      int   cyc;
      logic pend;
      logic overlap;
      reset_dut();
      drive(1'b1, W0, 1'b1, W1, 1'b0, 1'b1);
      got = 0; cyc = 0; pend = 1'b0; overlap = 1'b0;
      while (got < 260 && cyc < 12000) begin
        step();
        eng_done = pend;
        pend = 1'b0;
        #1;
        if (gnt0 & gnt1) overlap = 1'b1;
        if (eng_start) begin
          if (got < 6)  check_val($sformatf("order%0d", got), {31'd0, gnt1}, got % 2);
          if (got == 6) check_val("errcnt6", err_cnt, 8'd6);
          got++;
          pend = 1'b1;
        end
        cyc++;
      end
      if (got < 260) check_val("sat_budget", got, 260);
      check_val("no_overlap", overlap, 1'b0);
      step();
      eng_done = pend;
      step();
      eng_done = 1'b0;
      #1;
      check_val("err_sat", err_cnt, 8'd255);
    end

    // Reset in the middle of WAIT
    reset_dut();
    drive(1'b1, W0, 1'b1, W1, 1'b0, 1'b0);
    step();
    step();
    step();
    #1;
    camera_rstn = 1'b0;
    #1;
    check_obs("rst_async", mk(9'b000000000, '0, 8'd0));
    step();
    camera_rstn = 1'b1;
    #1;
    check_val("rst_idle", busy, 1'b0);
    step();
    #1;
    check_val("rst_first_gnt", {gnt1, gnt0}, 2'b01);

    // Randomized run against the transaction model
    reset_dut();
    m_active = 0; m_tl = 0; m_tidle = 0; m_owner = 0; m_last = 1;
    m_edata = '0; m_errcnt = 0;
    begin
      int   resp_at;
      logic r0, r1;
      logic [31:0] d0, d1;
      resp_at = -1;
      r0 = 1'b0; r1 = 1'b0; d0 = $urandom; d1 = $urandom;
      for (int t = 0; t < 6000; t++) begin
        obs_t exp;
        logic dn, nk;
        if (t > 0) step();
        if ($urandom_range(0, 7) == 0) r0 = ~r0;
        if ($urandom_range(0, 7) == 0) r1 = ~r1;
        if ($urandom_range(0, 3) == 0) d0 = $urandom;
        if ($urandom_range(0, 3) == 0) d1 = $urandom;
        dn = (t == resp_at) || ($urandom_range(0, 63) == 0);
        nk = $urandom_range(0, 1) == 1;
        drive(r0, d0, r1, d1, dn, nk);
        #1;

        exp = mk(9'b0, m_edata, 8'(m_errcnt));
        if (m_active) begin
          exp.busy = 1'b1;
          exp.gnt0 = ~m_owner;
          exp.gnt1 = m_owner;
          if (t == m_tl) begin
            exp.eng_start = 1'b1;
          end else if (dn || (t - m_tl) == TMO) begin
            logic e;
            e = dn ? nk : 1'b1;
            if (m_owner) begin exp.done1 = 1'b1; exp.err1 = e; end
            else         begin exp.done0 = 1'b1; exp.err0 = e; end
            exp.eng_abort = ~dn;
            if (e && m_errcnt < 255) m_errcnt++;
            m_active = 0;
            m_tidle  = t + GAP + 1;
          end
        end else if (t < m_tidle) begin
          exp.busy = 1'b1;
        end else if (r0 || r1) begin
          m_owner  = (r0 && r1) ? ~m_last : r1;
          m_last   = m_owner;
          m_edata  = m_owner ? d1 : d0;
          m_active = 1;
          m_tl     = t + 1;
        end
        check_obs($sformatf("rand_t%0d", t), exp);

        if (eng_start) resp_at = t + int'($urandom_range(1, TMO + 5));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
